vram_shadow: RTL and testbench



---
 rtl/zx_mem_pkg.sv | 18 +
 rtl/vram_wfifo.sv | 46 ++++
 rtl/vram_shadow.sv | 129 ++++++++++++
 tb/tb_vram_shadow.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/zx_mem_pkg.sv
// Shared memory-map constants and types for the screen-memory shadow.
package zx_mem_pkg;

    localparam logic [2:0] BANK_SCR0 = 3'd5;
    localparam logic [2:0] BANK_SCR1 = 3'd7;

    typedef struct packed {
        logic [14:0] a;
        logic [7:0]  d;
    } vwr_t;

    typedef enum logic [1:0] {
        ARB_FETCH,
        ARB_DRAIN,
        ARB_REFRESH
    } arb_op_t;

endpackage

// File: rtl/vram_wfifo.sv
// Posted-write FIFO: in-order queue of snooped shadow writes.
module vram_wfifo
    import zx_mem_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        i_push,
    input  logic [22:0] i_wdata,
    input  logic        i_pop,
    output logic        o_full,
    output logic        o_empty,
    output logic [22:0] o_head
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    vwr_t           r_mem [FIFO_DEPTH];
    logic [AW:0]    r_wp;
    logic [AW:0]    r_rp;
    logic           w_do_push;
    logic           w_do_pop;

    assign o_empty   = (r_wp == r_rp);
    assign o_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_head    = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_do_push) r_wp <= r_wp + 1'b1;
            if (w_do_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_do_push) r_mem[r_wp[AW-1:0]] <= vwr_t'(i_wdata);
    end

endmodule

// File: rtl/vram_shadow.sv
// Shadow of RAM banks 5/7: snoops CPU writes, serves video fetches from one
// single-port RAM with a fetch > drain > refresh priority arbiter.
module vram_shadow
    import zx_mem_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  din,
    input  logic        nMREQ,
    input  logic        nWR,
    input  logic        m128,
    input  logic [2:0]  page_ram,
    input  logic [14:0] vram_addr,
    output logic [7:0]  vram_dout,
    output logic        wr_ovf
);

    logic [7:0]  r_ram [0:32767];
    logic [7:0]  r_dout;
    logic        r_old_wr;
    logic        r_ovf;
    logic [14:0] r_aq;
    logic        r_aq_vld;

    logic        w_wr;
    logic        w_hit;
    logic [14:0] w_sa;
    logic        w_push_req;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [22:0] w_head_raw;
    vwr_t        w_head;
    vwr_t        w_wentry;
    arb_op_t     w_op;
    logic [14:0] w_ram_a;
    logic        w_ram_we;

    assign w_wr = ~nMREQ & ~nWR;

    always_comb begin
        w_hit = 1'b0;
        w_sa  = '0;
        if (addr[15:14] == 2'b01) begin
            w_hit = 1'b1;
            w_sa  = {1'b0, addr[13:0]};
        end else if (m128 && addr[15:14] == 2'b11 && page_ram == BANK_SCR0) begin
            w_hit = 1'b1;
            w_sa  = {1'b0, addr[13:0]};
        end else if (m128 && addr[15:14] == 2'b11 && page_ram == BANK_SCR1) begin
            w_hit = 1'b1;
            w_sa  = {1'b1, addr[13:0]};
        end
    end

    assign w_push_req = w_wr & ~r_old_wr & w_hit;
    assign w_wentry   = '{a: w_sa, d: din};
    assign w_head     = vwr_t'(w_head_raw);

    always_comb begin
        w_op = ARB_REFRESH;
        if (!r_aq_vld || vram_addr != r_aq) w_op = ARB_FETCH;
        else if (!w_empty)                  w_op = ARB_DRAIN;
    end

    assign w_pop  = (w_op == ARB_DRAIN);
    assign w_push = w_push_req & (~w_full | w_pop);

    always_comb begin
        w_ram_a = r_aq;
        case (w_op)
            ARB_FETCH: w_ram_a = vram_addr;
            ARB_DRAIN: w_ram_a = w_head.a;
            default:   w_ram_a = r_aq;
        endcase
    end

    // Gated by reset so an entry at the head on the reset cycle is lost too.
    assign w_ram_we = (w_op == ARB_DRAIN) & ~reset;

    vram_wfifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_wfifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (w_wentry),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head_raw)
    );

    always_ff @(posedge clk_sys) begin
        if (w_ram_we) r_ram[w_ram_a] <= w_head.d;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_dout <= '0;
        end else if (w_op == ARB_DRAIN) begin
            if (w_head.a == r_aq) r_dout <= w_head.d;
        end else begin
            r_dout <= r_ram[w_ram_a];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_old_wr <= 1'b0;
            r_ovf    <= 1'b0;
            r_aq     <= '0;
            r_aq_vld <= 1'b0;
        end else begin
            r_old_wr <= w_wr;
            if (w_push_req && w_full && !w_pop) r_ovf <= 1'b1;
            if (w_op == ARB_FETCH) begin
                r_aq     <= vram_addr;
                r_aq_vld <= 1'b1;
            end
        end
    end

    assign vram_dout = r_dout;
    assign wr_ovf    = r_ovf;

endmodule

// File: tb/tb_vram_shadow.sv
// Self-checking bench for vram_shadow: decode table plus multi-cycle corner cases.
module tb_vram_shadow;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        nMREQ;
    logic        nWR;
    logic        m128;
    logic [2:0]  page_ram;
    logic [14:0] vram_addr;
    logic [7:0]  vram_dout;
    logic        wr_ovf;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    typedef struct packed {
        logic [14:0] a;
        logic [7:0]  d;
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
        logic        m;
        logic [2:0]  pg;
        logic [14:0] probe;
        logic [7:0]  exp_d;
    } vec_t;

    exp_t sbq[$];
    vec_t vt [11];

    vram_shadow #(.FIFO_DEPTH(4)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .addr      (addr),
        .din       (din),
        .nMREQ     (nMREQ),
        .nWR       (nWR),
        .m128      (m128),
        .page_ram  (page_ram),
        .vram_addr (vram_addr),
        .vram_dout (vram_dout),
        .wr_ovf    (wr_ovf)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp_v);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp_v);
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        addr  = a;
        din   = d;
        nMREQ = 1'b0;
        nWR   = 1'b0;
        step(1);
        nMREQ = 1'b1;
        nWR   = 1'b1;
        step(1);
    endtask

    task automatic probe_next(input string name);
        exp_t e;
        if (sbq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty got 0 expected 1", name);
        end else begin
            e = sbq.pop_front();
            vram_addr = e.a;
            step(2);
            check8(name, vram_dout, e.d);
        end
    endtask

    initial begin
        reset = 1'b1; addr = '0; din = '0; nMREQ = 1'b1; nWR = 1'b1;
        m128 = 1'b0; page_ram = '0; vram_addr = '0;

        vt[0]  = '{a:16'hC123, d:8'h81, m:1'b1, pg:3'd7, probe:15'h4123, exp_d:8'h81};
        vt[1]  = '{a:16'hC123, d:8'h5A, m:1'b1, pg:3'd3, probe:15'h4123, exp_d:8'h81};
        vt[2]  = '{a:16'hC123, d:8'h66, m:1'b1, pg:3'd5, probe:15'h0123, exp_d:8'h66};
        vt[3]  = '{a:16'hC000, d:8'h22, m:1'b1, pg:3'd7, probe:15'h4000, exp_d:8'h22};
        vt[4]  = '{a:16'hC000, d:8'h11, m:1'b0, pg:3'd7, probe:15'h4000, exp_d:8'h22};
        vt[5]  = '{a:16'hC000, d:8'h12, m:1'b0, pg:3'd5, probe:15'h0000, exp_d:8'h3C};
        vt[6]  = '{a:16'h8000, d:8'h77, m:1'b1, pg:3'd7, probe:15'h0000, exp_d:8'h3C};
        vt[7]  = '{a:16'h7FFF, d:8'h99, m:1'b0, pg:3'd0, probe:15'h3FFF, exp_d:8'h99};
        vt[8]  = '{a:16'hFFFF, d:8'hE7, m:1'b1, pg:3'd7, probe:15'h7FFF, exp_d:8'hE7};
        vt[9]  = '{a:16'h3FFF, d:8'h55, m:1'b1, pg:3'd5, probe:15'h3FFF, exp_d:8'h99};
        vt[10] = '{a:16'hBFFF, d:8'h44, m:1'b1, pg:3'd7, probe:15'h7FFF, exp_d:8'hE7};

        step(3);
        check8("reset_dout", vram_dout, 8'h00);
        check1("reset_ovf", wr_ovf, 1'b0);
        reset = 1'b0;
        step(1);

        // Preload through the CPU path; later tests rely on these bytes.
        cpu_write(16'h4000, 8'hAA);
        cpu_write(16'h4204, 8'h5E);
        cpu_write(16'h4300, 8'h31);
        cpu_write(16'h4301, 8'h32);
        cpu_write(16'h4302, 8'h33);
        step(6);

        // Reset must not clear RAM contents.
        reset = 1'b1;
        step(2);
        check8("rst_hold_dout", vram_dout, 8'h00);
        reset = 1'b0;
        vram_addr = 15'h0000;
        step(2);
        check8("preload_fetch", vram_dout, 8'hAA);
        check1("preload_ovf", wr_ovf, 1'b0);

        // Write-through latency with vram_addr held on the written byte.
        cpu_write(16'h4000, 8'h3C);
        for (int i = 0; i < 4; i++) begin
            if (vram_dout == 8'h3C) break;
            step(1);
        end
        check8("wt_latency", vram_dout, 8'h3C);
        sbq.push_back('{a:15'h0000, d:8'h3C});
        vram_addr = 15'h1234;
        step(2);
        probe_next("wt_ram");

        // Decode table: probe held on the target address during the write.
        for (int i = 0; i < 11; i++) begin
            vram_addr = vt[i].probe;
            m128      = vt[i].m;
            page_ram  = vt[i].pg;
            step(2);
            cpu_write(vt[i].a, vt[i].d);
            sbq.push_back('{a:vt[i].probe, d:vt[i].exp_d});
            step(6);
            probe_next($sformatf("vec%0d", i));
        end
        m128 = 1'b0;
        page_ram = '0;

        // Back-to-back writes to one address: last one wins.
        vram_addr = 15'h0010;
        step(2);
        cpu_write(16'h4010, 8'h01);
        cpu_write(16'h4010, 8'h02);
        sbq.push_back('{a:15'h0010, d:8'h02});
        step(6);
        probe_next("b2b_last");

        // Starve DRAIN with a toggling vram_addr: 4 queued, 5th dropped.
        vram_addr = 15'h0100;
        step(2);
        for (int i = 0; i < 5; i++) begin
            logic [15:0] wa;
            case (i)
                0: wa = 16'h4200;
                1: wa = 16'h4201;
                2: wa = 16'h4202;
                3: wa = 16'h4200;
                default: wa = 16'h4204;
            endcase
            addr = wa; din = 8'hA0 + 8'(i); nMREQ = 1'b0; nWR = 1'b0;
            vram_addr = vram_addr ^ 15'h0001;
            step(1);
            nMREQ = 1'b1; nWR = 1'b1;
            vram_addr = vram_addr ^ 15'h0001;
            step(1);
            if (i == 3) check1("ovf_before_full", wr_ovf, 1'b0);
        end
        check1("ovf_set", wr_ovf, 1'b1);
        sbq.push_back('{a:15'h0200, d:8'hA3});
        sbq.push_back('{a:15'h0201, d:8'hA1});
        sbq.push_back('{a:15'h0202, d:8'hA2});
        sbq.push_back('{a:15'h0204, d:8'h5E});
        vram_addr = 15'h0100;
        step(8);
        probe_next("ovf_order_0200");
        probe_next("ovf_0201");
        probe_next("ovf_0202");
        probe_next("ovf_dropped_0204");
        check1("ovf_sticky", wr_ovf, 1'b1);

        // Reset with 3 entries pending: they must never reach RAM.
        vram_addr = 15'h0100;
        step(2);
        for (int i = 0; i < 3; i++) begin
            addr = 16'h4300 + 16'(i); din = 8'hD0 + 8'(i); nMREQ = 1'b0; nWR = 1'b0;
            vram_addr = vram_addr ^ 15'h0001;
            step(1);
            nMREQ = 1'b1; nWR = 1'b1;
            vram_addr = vram_addr ^ 15'h0001;
            step(1);
        end
        reset = 1'b1;
        step(1);
        check8("midrst_dout", vram_dout, 8'h00);
        check1("midrst_ovf", wr_ovf, 1'b0);
        reset = 1'b0;
        vram_addr = 15'h0100;
        sbq.push_back('{a:15'h0300, d:8'h31});
        sbq.push_back('{a:15'h0301, d:8'h32});
        sbq.push_back('{a:15'h0302, d:8'h33});
        step(8);
        probe_next("midrst_0300");
        probe_next("midrst_0301");
        probe_next("midrst_0302");
        check1("midrst_ovf_after", wr_ovf, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
